seven_segment_scan_controller: RTL and testbench
================================================

// Module: seven_segment_scan_controller
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode 7-segment bank (Nexys A7: 8 digits).
//  - Displays a hex word, or a fixed status message (Init / donE / Err).
//  - Tear-free value updates, leading-zero blanking, per-digit decimal points, PWM brightness, blink.
//  - Sits between the FPMAC result/status logic and the board display pins.
// PARAMETERS
//  NUM_DIGITS    8       digits scanned, legal 4..8; value width = 4*NUM_DIGITS
//  PRESCALE      262144  clk cycles per digit slot (~2.6 ms @100 MHz); sim uses 4
//  BLINK_FRAMES  32      full scan frames per blink half-period
// PORTS
//  clock_100Mhz  in   1             system clock
//  reset         in   1             asynchronous, active-low
//  value         in   4*NUM_DIGITS  hex word; nibble i shown on digit i (digit NUM_DIGITS-1 = leftmost)
//  value_valid   in   1             1-cycle strobe: capture value/dp_mask into pending regs
//  dp_mask       in   NUM_DIGITS    1 = light decimal point of digit i
//  mode          in   2             0 hex, 1 "Init", 2 "donE", 3 "Err"
//  blank_lz      in   1             1 = blank leading zero digits (hex mode only)
//  blink_en      in   1             1 = whole display blinks
//  brightness    in   4             0 = dark, 15 = full on
//  value_ack     out  1             1-cycle pulse: pending value moved to display regs
//  anode_n       out  NUM_DIGITS    active-low digit enables
//  cathode_n     out  7             active-low segments {g,f,e,d,c,b,a}
//  dp_n          out  1             active-low decimal point
// BEHAVIOUR
//  Reset (async, any time): anode_n all 1, cathode_n 7'h7F, dp_n 1, value_ack 0; all counters,
//   pending/display regs, pending flag, blink phase cleared. Display dark until first frame after release.
//  Prescaler: pre_cnt 0..PRESCALE-1; slot_tick when pre_cnt == PRESCALE-1.
//  Scan: digit idx 0..NUM_DIGITS-1, increments on slot_tick, wraps to 0. frame_tick = slot_tick && idx == NUM_DIGITS-1.
//  Capture: on value_valid, load pending_val/pending_dp and set pend flag.
//   - A second strobe before commit overwrites (latest wins).
//  Commit, on frame_tick only:
//   - If pend: pending -> display regs, clear pend, value_ack = 1 next cycle.
//   - mode is sampled into mode_r at every frame_tick; a mid-frame change never splits a frame.
//   - value_valid coincident with frame_tick: commit old pending, capture new, pend stays 1.
//  Glyph for slot idx:
//   - mode_r=0: hex of display nibble idx (standard 0-F table).
//     With blank_lz: blank if this and all higher nibbles are 0; digit 0 never blanked (0x0 shows "0").
//   - mode_r!=0: the 4 leftmost digits (idx NUM_DIGITS-1..NUM_DIGITS-4) show the message left to right;
//     remaining digits blank; dp off.
//  PWM: pwm = pre_cnt[top 4 bits of prescaler].
//   - Anode on when pwm < brightness; brightness 15 forces always on; 0 forces off.
//  Blink: phase toggles every BLINK_FRAMES frame_ticks while blink_en=1.
//   - Phase off blanks all anodes. blink_en=0 clears phase to on.
//  Outputs registered: anode/cathode/dp update 1 cycle after idx change; exactly one anode low when lit.
// STRUCTURE
//  Package seg7_pkg:
//   - SEG_* glyph constants: hex 0-F, I n i t d o E r, BLANK=7'h7F.
//   - MODE_HEX/INIT/DONE/ERR encodings.
//  Sub-module seg7_hex_decoder: 4-bit nibble -> 7-bit active-low pattern, combinational.
//  Top: prescaler, scan counter, pending/commit regs, blink counter, glyph mux, output regs.
// TESTING  (NUM_DIGITS=8, PRESCALE=4, BLINK_FRAMES=2)
//  1. Reset mid-scan -> outputs go anode_n=8'hFF, cathode_n=7'h7F same cycle, no clock edge.
//  2. value=32'h1234ABCD strobe, brightness=15, mode=0 -> after next frame_tick value_ack pulses once;
//     leftmost slot cathode_n=7'b1111001 ("1"), rightmost 7'b0100001 ("d").
//  3. blank_lz=1, value=32'h000000A0 -> digits 7..2 blank, digit1 "A" 7'b0001000, digit0 "0" 7'b1000000.
//  4. mode=2 changed mid-frame -> current frame still hex; next frame digits 7..4 "d o n E", 3..0 blank.
//  5. Strobes 32'h11111111 then 32'h22222222 within one frame -> one value_ack, display all "2".
//  6. brightness=4 -> each slot lit 4/16 of pre_cnt; blink_en=1 -> all anodes high for 2 frames, lit 2 frames.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph table and display-mode encodings for the 7-segment scan driver.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        MODE_HEX  = 2'd0,
        MODE_INIT = 2'd1,
        MODE_DONE = 2'd2,
        MODE_ERR  = 2'd3
    } mode_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_I_LO  = 7'b1111011;
    localparam logic [6:0] SEG_T     = 7'b0000111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // pos 0 is the leftmost message character
    function automatic logic [6:0] msg_glyph(
        input mode_t      m,
        input logic [1:0] pos
    );
        logic [6:0] g;
        g = SEG_BLANK;
        case (m)
            MODE_INIT: begin
                case (pos)
                    2'd0:    g = SEG_I;
                    2'd1:    g = SEG_N;
                    2'd2:    g = SEG_I_LO;
                    default: g = SEG_T;
                endcase
            end
            MODE_DONE: begin
                case (pos)
                    2'd0:    g = SEG_D;
                    2'd1:    g = SEG_O;
                    2'd2:    g = SEG_N;
                    default: g = SEG_E;
                endcase
            end
            MODE_ERR: begin
                case (pos)
                    2'd0:    g = SEG_E;
                    2'd1:    g = SEG_R;
                    2'd2:    g = SEG_R;
                    default: g = SEG_BLANK;
                endcase
            end
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0:    o_seg = SEG_0;
            4'h1:    o_seg = SEG_1;
            4'h2:    o_seg = SEG_2;
            4'h3:    o_seg = SEG_3;
            4'h4:    o_seg = SEG_4;
            4'h5:    o_seg = SEG_5;
            4'h6:    o_seg = SEG_6;
            4'h7:    o_seg = SEG_7;
            4'h8:    o_seg = SEG_8;
            4'h9:    o_seg = SEG_9;
            4'hA:    o_seg = SEG_A;
            4'hB:    o_seg = SEG_B;
            4'hC:    o_seg = SEG_C;
            4'hD:    o_seg = SEG_D;
            4'hE:    o_seg = SEG_E;
            default: o_seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed common-anode 7-segment driver: hex word or status
// message, frame-aligned updates, leading-zero blanking, PWM and blink.
module seven_segment_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 262144,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clock_100Mhz,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    value_valid,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [1:0]              mode,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    input  logic [3:0]              brightness,
    output logic                    value_ack,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [6:0]              cathode_n,
    output logic                    dp_n
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(PRESCALE);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0]         r_pre;
    logic [IW-1:0]         r_idx;
    logic [DW-1:0]         r_pend_val;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic                  r_pend;
    logic [DW-1:0]         r_disp_val;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    mode_t                 r_mode;
    logic                  r_lit;
    logic                  r_ack;
    logic [BW-1:0]         r_bcnt;
    logic                  r_blink_off;

    logic                  w_slot_tick;
    logic                  w_last;
    logic                  w_frame_tick;
    logic [PW+3:0]         w_pre_ext;
    logic [3:0]            w_pwm;
    logic                  w_pwm_on;
    logic [3:0]            w_nib;
    logic [6:0]            w_hex_seg;
    logic [DW-1:0]         w_hi;
    logic                  w_lz_blank;
    logic [IW-1:0]         w_pos;
    logic                  w_in_msg;
    logic [6:0]            w_glyph;
    logic                  w_dp_on;

    assign w_slot_tick  = (r_pre == PW'(PRESCALE - 1));
    assign w_last       = (r_idx == IW'(NUM_DIGITS - 1));
    assign w_frame_tick = w_slot_tick && w_last;

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_slot_tick ? '0 : r_pre + PW'(1);
            if (w_slot_tick)
                r_idx <= w_last ? '0 : r_idx + IW'(1);
        end
    end

    // display regs and mode only move on a frame boundary, so no frame tears
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend     <= 1'b0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_mode     <= MODE_HEX;
            r_lit      <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= w_frame_tick && r_pend;
            if (w_frame_tick) begin
                r_mode <= mode_t'(mode);
                r_lit  <= 1'b1;
                if (r_pend) begin
                    r_disp_val <= r_pend_val;
                    r_disp_dp  <= r_pend_dp;
                end
            end
            if (value_valid) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_mask;
            end
            r_pend <= value_valid || (r_pend && !w_frame_tick);
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            r_bcnt      <= '0;
            r_blink_off <= 1'b0;
        end else if (!blink_en) begin
            r_bcnt      <= '0;
            r_blink_off <= 1'b0;
        end else if (w_frame_tick) begin
            if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
                r_bcnt      <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end
        end
    end

    // zero-extend below so short sim prescalers still yield a 4-bit duty
    assign w_pre_ext = {r_pre, 4'b0000};
    assign w_pwm     = w_pre_ext[PW+3 -: 4];
    assign w_pwm_on  = (brightness == 4'hF) || (w_pwm < brightness);

    assign w_nib      = r_disp_val[{r_idx, 2'b00} +: 4];
    assign w_hi       = r_disp_val >> {r_idx, 2'b00};
    assign w_lz_blank = blank_lz && (r_idx != '0) && (w_hi == '0);
    assign w_pos      = IW'(NUM_DIGITS - 1) - r_idx;
    assign w_in_msg   = ({{(32-IW){1'b0}}, w_pos} < 32'd4);

    seg7_hex_decoder u_hex (
        .i_nibble (w_nib),
        .o_seg    (w_hex_seg)
    );

    always_comb begin
        w_glyph = SEG_BLANK;
        w_dp_on = 1'b0;
        if (r_mode == MODE_HEX) begin
            w_glyph = w_lz_blank ? SEG_BLANK : w_hex_seg;
            w_dp_on = r_disp_dp[r_idx];
        end else if (w_in_msg) begin
            w_glyph = msg_glyph(r_mode, w_pos[1:0]);
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            anode_n   <= '1;
            cathode_n <= SEG_BLANK;
            dp_n      <= 1'b1;
        end else begin
            if (r_lit && !r_blink_off && w_pwm_on)
                anode_n <= ~(NUM_DIGITS'(1) << r_idx);
            else
                anode_n <= '1;
            cathode_n <= r_lit ? w_glyph : SEG_BLANK;
            dp_n      <= ~(r_lit && w_dp_on);
        end
    end

    assign value_ack = r_ack;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Randomized bench for seven_segment_scan_controller against an
// arithmetic reference of the scan timeline, plus directed scenarios.
module tb_seven_segment_scan_controller;

    localparam int N  = 8;
    localparam int P  = 4;
    localparam int BF = 2;
    localparam int FR = N * P;

    logic          clock_100Mhz = 1'b0;
    logic          reset        = 1'b0;
    logic [31:0]   value        = '0;
    logic          value_valid  = 1'b0;
    logic [7:0]    dp_mask      = '0;
    logic [1:0]    mode         = '0;
    logic          blank_lz     = 1'b0;
    logic          blink_en     = 1'b0;
    logic [3:0]    brightness   = 4'hF;
    logic          value_ack;
    logic [7:0]    anode_n;
    logic [6:0]    cathode_n;
    logic          dp_n;

    seven_segment_scan_controller #(
        .NUM_DIGITS   (N),
        .PRESCALE     (P),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .value        (value),
        .value_valid  (value_valid),
        .dp_mask      (dp_mask),
        .mode         (mode),
        .blank_lz     (blank_lz),
        .blink_en     (blink_en),
        .brightness   (brightness),
        .value_ack    (value_ack),
        .anode_n      (anode_n),
        .cathode_n    (cathode_n),
        .dp_n         (dp_n)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    logic [6:0] hex_g [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [6:0] msg_g [4][4] = '{
        '{7'h7F, 7'h7F, 7'h7F, 7'h7F},
        '{7'h79, 7'h2B, 7'h7B, 7'h07},
        '{7'h21, 7'h23, 7'h2B, 7'h06},
        '{7'h06, 7'h2F, 7'h2F, 7'h7F}
    };

    int total   = 0;
    int bad     = 0;
    int ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference state: what the display should be doing, by frame arithmetic
    int          m_n;
    logic [31:0] m_pv, m_disp;
    logic [7:0]  m_pdp, m_ddp;
    logic        m_pend, m_lit, m_boff;
    int          m_bcnt, m_mode;
    logic [7:0]  e_an;
    logic [6:0]  e_cat;
    logic        e_dp, e_ack;

    always @(posedge clock_100Mhz or negedge reset) begin : mdl
        int pre, idx, pwm, pos;
        logic on, ft;
        logic [31:0] hi;
        if (!reset) begin
            m_n = 0; m_pv = 0; m_disp = 0; m_pdp = 0; m_ddp = 0;
            m_pend = 0; m_lit = 0; m_boff = 0; m_bcnt = 0; m_mode = 0;
            e_an = 8'hFF; e_cat = 7'h7F; e_dp = 1'b1; e_ack = 1'b0;
        end else begin
            pre = m_n % P;
            idx = (m_n / P) % N;
            pwm = pre * 16 / P;
            on  = (brightness == 15) || (pwm < int'(brightness));
            e_an = (m_lit && !m_boff && on) ? ~(8'h01 << idx) : 8'hFF;
            hi = m_disp >> (4 * idx);
            if (!m_lit)
                e_cat = 7'h7F;
            else if (m_mode == 0)
                e_cat = (blank_lz && idx != 0 && hi == 0) ? 7'h7F : hex_g[hi[3:0]];
            else begin
                pos = N - 1 - idx;
                e_cat = (pos < 4) ? msg_g[m_mode][pos] : 7'h7F;
            end
            e_dp  = !(m_lit && m_mode == 0 && m_ddp[idx]);
            ft    = (m_n % FR) == FR - 1;
            e_ack = ft && m_pend;
            if (ft) begin
                if (m_pend) begin
                    m_disp = m_pv; m_ddp = m_pdp; m_pend = 0;
                end
                m_mode = int'(mode);
                m_lit  = 1;
                if (blink_en) begin
                    m_bcnt++;
                    if (m_bcnt == BF) begin
                        m_bcnt = 0; m_boff = !m_boff;
                    end
                end
            end
            if (!blink_en) begin
                m_bcnt = 0; m_boff = 0;
            end
            if (value_valid) begin
                m_pv = value; m_pdp = dp_mask; m_pend = 1;
            end
            m_n++;
        end
    end

    always @(negedge clock_100Mhz) begin
        if (reset) begin
            chk("anode", 32'(anode_n), 32'(e_an));
            chk("cathode", 32'(cathode_n), 32'(e_cat));
            chk("dp", 32'(dp_n), 32'(e_dp));
            chk("ack", 32'(value_ack), 32'(e_ack));
            if (value_ack) ack_cnt++;
        end
    end

    task automatic strobe(input logic [31:0] v);
        @(negedge clock_100Mhz);
        value = v; dp_mask = '0; value_valid = 1'b1;
        @(negedge clock_100Mhz);
        value_valid = 1'b0;
    endtask

    // skips the current slot of digit d, then returns its next segments
    task automatic seg_of(input int d, output logic [6:0] seg);
        logic [7:0] tgt;
        int k;
        tgt = ~(8'h01 << d);
        seg = 7'bx;
        k = 0;
        while (anode_n == tgt && k < 4 * FR) begin
            @(negedge clock_100Mhz); k++;
        end
        while (k < 4 * FR) begin
            @(negedge clock_100Mhz); k++;
            if (anode_n == tgt) begin
                seg = cathode_n;
                break;
            end
        end
    endtask

    initial begin
        logic [6:0] s;
        int lit, dark;
        repeat (3) @(negedge clock_100Mhz);
        #2 reset = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clock_100Mhz);
            value_valid = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                value = $urandom >> (4 * $urandom_range(0, 8));
                dp_mask = 8'($urandom);
                value_valid = 1'b1;
            end
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 255) == 0) blink_en = ~blink_en;
        end
        @(negedge clock_100Mhz);
        value_valid = 1'b0;

        #2 reset = 1'b0;
        #1;
        chk("rst_anode", 32'(anode_n), 32'hFF);
        chk("rst_cathode", 32'(cathode_n), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'h1);
        chk("rst_ack", 32'(value_ack), 32'h0);
        mode = 2'd0; brightness = 4'hF; blank_lz = 1'b0;
        blink_en = 1'b0; dp_mask = '0;
        @(negedge clock_100Mhz);
        #2 reset = 1'b1;
        ack_cnt = 0;

        strobe(32'h1234ABCD);
        repeat (3 * FR) @(negedge clock_100Mhz);
        chk("ack_once", 32'(ack_cnt), 32'd1);
        seg_of(7, s); chk("hex_d7", 32'(s), 32'h79);
        seg_of(0, s); chk("hex_d0", 32'(s), 32'h21);

        blank_lz = 1'b1;
        strobe(32'h000000A0);
        repeat (2 * FR) @(negedge clock_100Mhz);
        for (int d = 7; d >= 2; d--) begin
            seg_of(d, s); chk($sformatf("lz_d%0d", d), 32'(s), 32'h7F);
        end
        seg_of(1, s); chk("lz_d1", 32'(s), 32'h08);
        seg_of(0, s); chk("lz_d0", 32'(s), 32'h40);

        blank_lz = 1'b0;
        repeat (FR) @(negedge clock_100Mhz);
        seg_of(2, s);
        mode = 2'd2;
        seg_of(7, s); chk("midframe_d7", 32'(s), 32'h40);
        seg_of(6, s); chk("done_d6", 32'(s), 32'h23);
        seg_of(7, s); chk("done_d7", 32'(s), 32'h21);
        seg_of(5, s); chk("done_d5", 32'(s), 32'h2B);
        seg_of(4, s); chk("done_d4", 32'(s), 32'h06);
        seg_of(3, s); chk("done_d3", 32'(s), 32'h7F);
        seg_of(0, s); chk("done_d0", 32'(s), 32'h7F);
        mode = 2'd0;

        repeat (2 * FR) @(negedge clock_100Mhz);
        seg_of(0, s);
        #2 ack_cnt = 0;
        strobe(32'h11111111);
        strobe(32'h22222222);
        repeat (3 * FR) @(negedge clock_100Mhz);
        chk("latest_ack", 32'(ack_cnt), 32'd1);
        for (int d = 0; d < 8; d++) begin
            seg_of(d, s); chk($sformatf("latest_d%0d", d), 32'(s), 32'h24);
        end

        brightness = 4'd4;
        repeat (FR) @(negedge clock_100Mhz);
        lit = 0;
        for (int c = 0; c < FR; c++) begin
            @(negedge clock_100Mhz);
            if (anode_n != 8'hFF) lit++;
        end
        chk("pwm_lit", 32'(lit), 32'(FR / 4));

        brightness = 4'hF;
        blink_en = 1'b1;
        repeat (5 * FR) @(negedge clock_100Mhz);
        dark = 0;
        for (int c = 0; c < 8 * FR; c++) begin
            @(negedge clock_100Mhz);
            if (anode_n == 8'hFF) dark++;
        end
        chk("blink_dark", 32'(dark), 32'(4 * FR));
        blink_en = 1'b0;
        repeat (FR) @(negedge clock_100Mhz);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
